// File: rtl/adc_framer_pkg.sv
// ----------------------------------------------------------------------------
// adc_framer_pkg
// Shared definitions for the ADC-to-UART framer: FSM state type, frame
// geometry and the default sync byte.
//
// Build option: define FRAMER_CHECKSUM_EN to append an XOR checksum byte,
// which makes the frame six bytes long instead of five.
// ----------------------------------------------------------------------------
package adc_framer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int         FRAME_LEN_BASE    = 5;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

`ifdef FRAMER_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

  // Index of the final byte of a frame (the byte index is 3 bits wide).
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

endpackage

// File: rtl/framer_decimator.sv
// ----------------------------------------------------------------------------
// framer_decimator
// Counts qualifying samples and raises a one-cycle capture tick on every
// DECIMATION-th one. The tick is combinational so that the framer can latch
// the very sample that produced it.
//
// Ports:
//   i_clock    system clock (rising edge)
//   i_reset    synchronous active-high reset
//   i_qualify  a qualifying sample is present this cycle
//   o_tick     capture tick, valid in the same cycle as the sample
// ----------------------------------------------------------------------------
module framer_decimator #(
  parameter int DECIMATION = 1000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_qualify,
  output logic o_tick
);

  localparam logic [15:0] TERMINAL = 16'(DECIMATION - 1);

  logic [15:0] r_count;

  assign o_tick = i_qualify && (r_count == TERMINAL);

  // NOTE: sequential state is written with <= so every register in the
  // design samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_qualify) begin
      r_count <= o_tick ? 16'd0 : r_count + 16'd1;
    end
  end

endmodule

// File: rtl/adc_uart_framer.sv
// ----------------------------------------------------------------------------
// adc_uart_framer
// Decimates a stream of dual-channel ADC samples and serialises each chosen
// pair as a byte frame for a UART transmitter:
//   SYNC_BYTE, ch1[15:8], ch1[7:0], ch2[15:8], ch2[7:0] [, checksum]
// A capture tick that arrives while a frame is still in flight is counted in
// o_drop_count (saturating) instead of being framed.
//
// Build option: FRAMER_CHECKSUM_EN adds a sixth byte, the XOR of the four
// data bytes.
//
// Ports:
//   i_clock         system clock (rising edge)
//   i_reset         synchronous active-high reset
//   i_enable        framing permitted; gates new captures only
//   i_sample_valid  i_ch1_data / i_ch2_data carry a new pair
//   i_ch1_data      channel 1 sample
//   i_ch2_data      channel 2 sample
//   o_tx_data       byte offered to the UART
//   o_tx_valid      o_tx_data is valid
//   i_tx_ready      UART accepts the byte this cycle
//   o_busy          a frame is in flight
//   o_drop_count    decimated samples lost to an in-flight frame
// ----------------------------------------------------------------------------
module adc_uart_framer
  import adc_framer_pkg::*;
#(
  parameter int         DECIMATION = 1000,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_sample_valid,
  input  logic [15:0] i_ch1_data,
  input  logic [15:0] i_ch2_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic [15:0] o_drop_count
);

  state_t      r_state;
  logic [2:0]  r_byte_idx;
  logic [15:0] r_ch1;
  logic [15:0] r_ch2;

  logic        w_qualify;
  logic        w_tick;
  logic [2:0]  w_next_idx;

  assign w_qualify  = i_sample_valid & i_enable;
  assign w_next_idx = r_byte_idx + 3'd1;

  framer_decimator #(
    .DECIMATION (DECIMATION)
  ) u_decimator (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_qualify (w_qualify),
    .o_tick    (w_tick)
  );

  // Byte at position idx of the frame built from the latched pair.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [15:0] ch1,
                                            input logic [15:0] ch2);
    case (idx)
      3'd0:    frame_byte = SYNC_BYTE;
      3'd1:    frame_byte = ch1[15:8];
      3'd2:    frame_byte = ch1[7:0];
      3'd3:    frame_byte = ch2[15:8];
      3'd4:    frame_byte = ch2[7:0];
`ifdef FRAMER_CHECKSUM_EN
      3'd5:    frame_byte = ch1[15:8] ^ ch1[7:0] ^ ch2[15:8] ^ ch2[7:0];
`endif
      // NOTE: the default arm keeps every selector value assigned, so no
      // latch can be inferred when this is used in combinational context.
      default: frame_byte = 8'h00;
    endcase
  endfunction

  // Outputs are registered: the next byte is looked up one index ahead so
  // o_tx_data changes only on an accepted handshake and holds during stalls.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_byte_idx   <= '0;
      r_ch1        <= '0;
      r_ch2        <= '0;
      o_tx_data    <= '0;
      o_tx_valid   <= 1'b0;
      o_busy       <= 1'b0;
      o_drop_count <= '0;
    end else begin
      // A tick in the cycle the last byte is accepted is still a drop:
      // the state has not yet returned to IDLE.
      if (w_tick && (r_state != IDLE) && (o_drop_count != 16'hFFFF)) begin
        o_drop_count <= o_drop_count + 16'd1;
      end

      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_ch1      <= i_ch1_data;
            r_ch2      <= i_ch2_data;
            r_byte_idx <= '0;
            o_tx_data  <= SYNC_BYTE;
            o_tx_valid <= 1'b1;
            o_busy     <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (i_tx_ready) begin
            if (r_byte_idx == LAST_IDX) begin
              r_byte_idx <= '0;
              o_tx_data  <= '0;
              o_tx_valid <= 1'b0;
              o_busy     <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_byte_idx <= w_next_idx;
              o_tx_data  <= frame_byte(w_next_idx, r_ch1, r_ch2);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_uart_framer.sv
// ----------------------------------------------------------------------------
// tb_adc_uart_framer
// Two framers share one clock: dut4 (DECIMATION=4) for framing, stalls,
// reset and enable behaviour; dut1 (DECIMATION=1) for drop counting.
// A frame-level model (sample count modulo DECIMATION, a frame byte array
// and a delivery pointer) predicts the outputs of both every cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_uart_framer;

`ifdef FRAMER_CHECKSUM_EN
  localparam int FL = 6;
`else
  localparam int FL = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, en, sv, rdy;
  logic [1:0][15:0] ch1, ch2;
  logic [1:0]       valid, busy;
  logic [1:0][7:0]  data;
  logic [1:0][15:0] drops;

  adc_uart_framer #(.DECIMATION(4), .SYNC_BYTE(8'hA5)) dut4 (
    .i_clock(clk), .i_reset(rst[0]), .i_enable(en[0]), .i_sample_valid(sv[0]),
    .i_ch1_data(ch1[0]), .i_ch2_data(ch2[0]), .o_tx_data(data[0]),
    .o_tx_valid(valid[0]), .i_tx_ready(rdy[0]), .o_busy(busy[0]),
    .o_drop_count(drops[0]));

  adc_uart_framer #(.DECIMATION(1), .SYNC_BYTE(8'hA5)) dut1 (
    .i_clock(clk), .i_reset(rst[1]), .i_enable(en[1]), .i_sample_valid(sv[1]),
    .i_ch1_data(ch1[1]), .i_ch2_data(ch2[1]), .o_tx_data(data[1]),
    .o_tx_valid(valid[1]), .i_tx_ready(rdy[1]), .o_busy(busy[1]),
    .o_drop_count(drops[1]));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  int         m_nq    [2];
  int         m_pos   [2];   // next byte to deliver; FL means no frame
  int         m_drops [2];
  logic [7:0] m_frame [2][6];
  bit         m_live = 1'b0;
  bit         m_in_flight, m_tick;

  function automatic int dec_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        m_nq[k] = 0; m_pos[k] = FL; m_drops[k] = 0;
      end else begin
        m_in_flight = (m_pos[k] < FL);
        m_tick      = 1'b0;
        if (en[k] && sv[k]) begin
          m_nq[k]++;
          m_tick = ((m_nq[k] % dec_of(k)) == 0);
        end
        if (m_in_flight && rdy[k]) m_pos[k]++;
        if (m_tick) begin
          if (m_in_flight) begin
            if (m_drops[k] < 65535) m_drops[k]++;
          end else begin
            m_frame[k][0] = 8'hA5;
            m_frame[k][1] = ch1[k][15:8];
            m_frame[k][2] = ch1[k][7:0];
            m_frame[k][3] = ch2[k][15:8];
            m_frame[k][4] = ch2[k][7:0];
            m_frame[k][5] = m_frame[k][1] ^ m_frame[k][2] ^ m_frame[k][3] ^ m_frame[k][4];
            m_pos[k] = 0;
          end
        end
      end
    end
    m_live = 1'b1;
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("valid[%0d]", k), 32'(valid[k]), 32'(m_pos[k] < FL));
        check($sformatf("busy[%0d]", k),  32'(busy[k]),  32'(m_pos[k] < FL));
        check($sformatf("drops[%0d]", k), 32'(drops[k]), 32'(m_drops[k]));
        if (m_pos[k] < FL)
          check($sformatf("data[%0d]", k), 32'(data[k]), 32'(m_frame[k][m_pos[k]]));
      end
    end
  end

  // Log of bytes accepted by dut4's UART.
  logic [7:0] log_q[$];
  always @(negedge clk) begin
    if (rst[0] === 1'b0 && valid[0] === 1'b1 && rdy[0] === 1'b1)
      log_q.push_back(data[0]);
  end

  // ---------------- stimulus helpers ----------------
  // Inputs change only 1 ns after a rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample0(input logic e, input logic [15:0] a, input logic [15:0] b);
    en[0] = e; sv[0] = 1'b1; ch1[0] = a; ch2[0] = b;
    cyc();
    sv[0] = 1'b0;
  endtask

  task automatic wait_idle0(input string name);
    int n = 0;
    while (busy[0] === 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    check({name, "_idle_timeout"}, 32'(busy[0]), 32'd0);
  endtask

  task automatic check_frame(input string name, input int base, input logic [7:0] exp [6]);
    for (int i = 0; i < FL; i++) begin
      if (base + i < log_q.size())
        check($sformatf("%s_byte%0d", name, i), 32'(log_q[base + i]), 32'(exp[i]));
      else
        check($sformatf("%s_byte%0d_missing", name, i), 32'(log_q.size()), 32'(base + i + 1));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 2'b11; en = '0; sv = '0; rdy = '0; ch1 = '0; ch2 = '0;
    cyc(); cyc();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_valid%0d", k), 32'(valid[k]), 32'd0);
      check($sformatf("reset_busy%0d", k),  32'(busy[k]),  32'd0);
      check($sformatf("reset_data%0d", k),  32'(data[k]),  32'd0);
      check($sformatf("reset_drops%0d", k), 32'(drops[k]), 32'd0);
    end
    rst = 2'b00;

    // DECIMATION=1, continuous samples: every tick during a frame is a drop.
    // 12 ticks: 2 captures, 10 drops (both 5- and 6-byte frames).
    en[1] = 1'b1; sv[1] = 1'b1; rdy[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ch1[1] = 16'(i * 16'h0101);
      ch2[1] = ~ch1[1];
      cyc();
    end
    check("dec1_drops_after_12", 32'(drops[1]), 32'd10);
    sv[1] = 1'b0;

    // 8 spaced samples, ready high: frames from the 4th and 8th samples.
    log_q.delete();
    rdy[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4)      sample0(1'b1, 16'h1234, 16'hABCD);
      else if (i == 8) sample0(1'b1, 16'h5A0F, 16'h00FF);
      else             sample0(1'b1, 16'(16'hF000 + i), 16'(16'h0F00 + i));
      cyc();
    end
    wait_idle0("two_frames");
    check("two_frames_bytes", 32'(log_q.size()), 32'(2 * FL));
    // Checksums are the XOR of the four data bytes: 12^34^AB^CD = 40,
    // 5A^0F^00^FF = AA.
    check_frame("frame_1234", 0,  '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40});
    check_frame("frame_5a0f", FL, '{8'hA5, 8'h5A, 8'h0F, 8'h00, 8'hFF, 8'hAA});

    // Back-pressure: ready low for 10 cycles while byte 2 is offered.
    log_q.delete();
    for (int i = 1; i <= 4; i++) sample0(1'b1, 16'hC3D2, 16'h7E81);
    check("stall_first_sync", 32'(data[0]), 32'hA5);
    cyc(); cyc();
    rdy[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check($sformatf("stall_data_%0d", i),  32'(data[0]),  32'hD2);
      check($sformatf("stall_valid_%0d", i), 32'(valid[0]), 32'd1);
    end
    rdy[0] = 1'b1;
    wait_idle0("stall");
    check("stall_bytes", 32'(log_q.size()), 32'(FL));
    check_frame("stall_frame", 0, '{8'hA5, 8'hC3, 8'hD2, 8'h7E, 8'h81, 8'hEE});

    // 8 back-to-back samples: the 8th tick lands mid-frame and is dropped.
    for (int i = 1; i <= 8; i++) sample0(1'b1, 16'(16'h0100 * i), 16'(i));
    wait_idle0("drop");
    check("drop_count_one", 32'(drops[0]), 32'd1);

    // Reset pulse while byte 2 is offered.
    for (int i = 1; i <= 4; i++) sample0(1'b1, 16'h3344, 16'h5566);
    cyc(); cyc();
    check("pre_reset_byte2", 32'(data[0]), 32'h44);
    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    check("midreset_valid", 32'(valid[0]), 32'd0);
    check("midreset_busy",  32'(busy[0]),  32'd0);
    check("midreset_drops", 32'(drops[0]), 32'd0);
    log_q.delete();
    for (int i = 1; i <= 4; i++) sample0(1'b1, 16'h6161, 16'h7272);
    wait_idle0("post_reset");
    check("post_reset_bytes", 32'(log_q.size()), 32'(FL));
    check_frame("post_reset", 0, '{8'hA5, 8'h61, 8'h61, 8'h72, 8'h72, 8'h00});

    // Enable low: samples neither frame nor advance the count.
    for (int i = 0; i < 6; i++) sample0(1'b0, 16'hDEAD, 16'hBEEF);
    check("disabled_no_frame", 32'(busy[0]), 32'd0);
    for (int i = 0; i < 3; i++) sample0(1'b1, 16'h0001, 16'h0002);
    check("three_enabled_no_frame", 32'(busy[0]), 32'd0);
    log_q.delete();
    sample0(1'b1, 16'h8899, 16'h1122);
    check("fourth_enabled_frames", 32'(busy[0]), 32'd1);
    // Enable dropped mid-frame: the frame still completes.
    for (int i = 0; i < 8; i++) sample0(1'b0, 16'hFFFF, 16'hFFFF);
    wait_idle0("enable_drop");
    check("enable_drop_bytes", 32'(log_q.size()), 32'(FL));
    check_frame("enable_drop", 0, '{8'hA5, 8'h88, 8'h99, 8'h11, 8'h22, 8'h22});
    check("enable_drop_no_drops", 32'(drops[0]), 32'd0);

    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
